// File: rtl/clint_timer_pkg.sv
// clint_timer_pkg: register offsets and bus FSM states for the CLINT
package clint_timer_pkg;
    localparam logic [15:0] CLINT_MSIP_OFF        = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_LO_OFF = 16'h4000;
    localparam logic [15:0] CLINT_MTIMECMP_HI_OFF = 16'h4004;
    localparam logic [15:0] CLINT_MTIME_LO_OFF    = 16'hBFF8;
    localparam logic [15:0] CLINT_MTIME_HI_OFF    = 16'hBFFC;
    typedef enum logic {IDLE, RESP} bus_state_t;
endpackage

// File: rtl/clint_timer_if.sv
// clint_timer_if: valid/ready data bus between the core and the CLINT
interface clint_timer_if;
    logic        sel;
    logic        valid;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        ready;
    modport master (output sel, valid, addr, wdata, wstrb, input rdata, ready);
    modport slave  (input sel, valid, addr, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/clint_timer_counter.sv
// clint_timer_counter: free-running 0..MODULO-1 counter with a wrap pulse
module clint_timer_counter #(
    parameter int WIDTH  = 16,
    parameter int MODULO = 1
) (
    input  logic clk,
    input  logic resetn,
    output logic wrap
);
    logic [WIDTH-1:0] cnt;

    assign wrap = cnt == WIDTH'(MODULO - 1);

    always_ff @(posedge clk)
        if (!resetn) cnt <= '0;
        else         cnt <= wrap ? '0 : cnt + 1'b1;
endmodule

// File: rtl/clint_timer.sv
// clint_timer: memory-mapped mtime/mtimecmp/msip driving the software and timer interrupts
module clint_timer
    import clint_timer_pkg::*;
#(
    parameter int          TICK_DIV     = 1,
    parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic         clk,
    input  logic         resetn,
    clint_timer_if.slave bus,
    output logic         IRQ3,
    output logic         IRQ7
);
    bus_state_t  state;
    logic [63:0] mtime, mtimecmp, mtime_inc, mtime_nxt;
    logic        msip, tick, ready_q, wr;
    logic [31:0] rdata_q, rd_word, req_wdata;
    logic [15:0] wa, req_addr;
    logic [3:0]  req_wstrb;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old, input logic [31:0] wdata,
                                                input logic [3:0] wstrb);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wstrb[i] ? wdata[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction

    clint_timer_counter #(.WIDTH(16), .MODULO(TICK_DIV)) u_presc (
        .clk(clk), .resetn(resetn), .wrap(tick)
    );

    assign wa      = bus.addr & 16'hFFFC;
    assign wr      = state == RESP && req_wstrb != 4'b0;
    assign rd_word = wa == CLINT_MSIP_OFF        ? {31'b0, msip}    :
                     wa == CLINT_MTIMECMP_LO_OFF ? mtimecmp[31:0]   :
                     wa == CLINT_MTIMECMP_HI_OFF ? mtimecmp[63:32]  :
                     wa == CLINT_MTIME_LO_OFF    ? mtime[31:0]      :
                     wa == CLINT_MTIME_HI_OFF    ? mtime[63:32]     : 32'b0;

    // A written word takes the bus bytes; the other word keeps the tick/carry from the pre-write value
    assign mtime_inc = tick ? mtime + 64'd1 : mtime;
    assign mtime_nxt = {(wr && req_addr == CLINT_MTIME_HI_OFF) ? apply_wstrb(mtime[63:32], req_wdata, req_wstrb)
                                                                : mtime_inc[63:32],
                        (wr && req_addr == CLINT_MTIME_LO_OFF) ? apply_wstrb(mtime[31:0], req_wdata, req_wstrb)
                                                                : mtime_inc[31:0]};

    assign IRQ3      = msip;
    assign bus.ready = ready_q;
    assign bus.rdata = rdata_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            mtime     <= '0;
            mtimecmp  <= MTIMECMP_RST;
            msip      <= 1'b0;
            IRQ7      <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_wstrb <= '0;
        end else begin
            mtime <= mtime_nxt;
            IRQ7  <= mtime >= mtimecmp;
            if (wr && req_addr == CLINT_MTIMECMP_LO_OFF)
                mtimecmp[31:0] <= apply_wstrb(mtimecmp[31:0], req_wdata, req_wstrb);
            if (wr && req_addr == CLINT_MTIMECMP_HI_OFF)
                mtimecmp[63:32] <= apply_wstrb(mtimecmp[63:32], req_wdata, req_wstrb);
            if (wr && req_addr == CLINT_MSIP_OFF && req_wstrb[0])
                msip <= req_wdata[0];
            if (state == IDLE && bus.sel && bus.valid) begin
                state     <= RESP;
                ready_q   <= 1'b1;
                rdata_q   <= rd_word;
                req_addr  <= wa;
                req_wdata <= bus.wdata;
                req_wstrb <= bus.wstrb;
            end else begin
                state   <= IDLE;
                ready_q <= 1'b0;
                rdata_q <= '0;
            end
        end
    end
endmodule

// File: tb/tb_clint_timer.sv
// tb_clint_timer: scoreboard-driven checks of the CLINT bus, mtime, and interrupt lines
module tb_clint_timer;
    import clint_timer_pkg::*;
    localparam int TICK_DIV = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        irq3, irq7;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          cap_cyc = 0;
    logic [31:0] exp_q[$];

    clint_timer_if bus ();

    clint_timer #(.TICK_DIV(TICK_DIV)) dut (
        .clk(clk), .resetn(resetn), .bus(bus), .IRQ3(irq3), .IRQ7(irq7)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic bus_xfer(input logic [15:0] a, input logic [31:0] wd, input logic [3:0] ws,
                            output logic [31:0] rd);
        int n = 0;
        @(negedge clk);
        bus.sel = 1'b1; bus.valid = 1'b1; bus.addr = a; bus.wdata = wd; bus.wstrb = ws;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.ready && n < 8);
        total++;
        if (n !== 1 || bus.ready !== 1'b1) begin
            bad++;
            $display("FAIL latency addr=%h got=%0d cycles ready=%b want=1 cycle", a, n, bus.ready);
        end
        rd = bus.rdata;
        cap_cyc = cyc;
        bus.sel = 1'b0; bus.valid = 1'b0; bus.wstrb = 4'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] dummy;
        bus_xfer(a, d, s, dummy);
    endtask

    task automatic rd_chk(input logic [15:0] a, input logic [31:0] exp, input string name);
        logic [31:0] got, e;
        exp_q.push_back(exp);
        bus_xfer(a, 32'b0, 4'b0, got);
        e = exp_q.pop_front();
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL %s addr=%h got=%h want=%h", name, a, got, e);
        end
    endtask

    task automatic test_reset;
        logic [31:0] got;
        bus.sel = 1'b0; bus.valid = 1'b0; bus.addr = '0; bus.wdata = '0; bus.wstrb = '0;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", bus.ready); end
        total++; if (bus.rdata !== 32'b0) begin bad++; $display("FAIL rst_rdata got=%h want=0", bus.rdata); end
        total++; if (irq3 !== 1'b0) begin bad++; $display("FAIL rst_irq3 got=%b want=0", irq3); end
        total++; if (irq7 !== 1'b0) begin bad++; $display("FAIL rst_irq7 got=%b want=0", irq7); end
        resetn = 1'b1;
        rd_chk(CLINT_MTIMECMP_LO_OFF, 32'hFFFF_FFFF, "rst_cmp_lo");
        rd_chk(CLINT_MTIMECMP_HI_OFF, 32'hFFFF_FFFF, "rst_cmp_hi");
        bus_xfer(CLINT_MTIME_LO_OFF, 32'b0, 4'b0, got);
        total++; if (got > 32'd16) begin bad++; $display("FAIL rst_mtime got=%0d want<=16", got); end
        total++; if (irq3 !== 1'b0 || irq7 !== 1'b0) begin
            bad++; $display("FAIL rst_irqs got=%b%b want=00", irq3, irq7);
        end
    endtask

    task automatic test_tick;
        logic [31:0] t0, t1;
        int c0;
        bus_xfer(CLINT_MTIME_LO_OFF, 32'b0, 4'b0, t0);
        c0 = cap_cyc;
        repeat (38) @(negedge clk);
        bus_xfer(CLINT_MTIME_LO_OFF, 32'b0, 4'b0, t1);
        total++; if (cap_cyc - c0 != 40) begin bad++; $display("FAIL tick_window got=%0d want=40", cap_cyc - c0); end
        total++; if (t1 - t0 !== 32'd10) begin bad++; $display("FAIL tick_rate got=%0d want=10", t1 - t0); end
    endtask

    task automatic test_carry;
        logic [31:0] lo;
        wr(CLINT_MTIME_HI_OFF, 32'h0, 4'hF);
        wr(CLINT_MTIME_LO_OFF, 32'hFFFF_FFFF, 4'hF);
        repeat (6) @(negedge clk);
        rd_chk(CLINT_MTIME_HI_OFF, 32'h1, "carry_hi");
        bus_xfer(CLINT_MTIME_LO_OFF, 32'b0, 4'b0, lo);
        total++; if (lo > 32'd8) begin bad++; $display("FAIL carry_lo got=%h want<=8", lo); end
    endtask

    task automatic test_timer_irq;
        logic [31:0] m;
        int n = 0;
        wr(CLINT_MTIME_HI_OFF, 32'h0, 4'hF);
        bus_xfer(CLINT_MTIME_LO_OFF, 32'b0, 4'b0, m);
        wr(CLINT_MTIMECMP_HI_OFF, 32'hFFFF_FFFF, 4'hF);
        wr(CLINT_MTIMECMP_LO_OFF, m + 32'd20, 4'hF);
        wr(CLINT_MTIMECMP_HI_OFF, 32'h0, 4'hF);
        @(negedge clk);
        total++; if (irq7 !== 1'b0) begin bad++; $display("FAIL irq7_early got=%b want=0", irq7); end
        while (!irq7 && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++; if (irq7 !== 1'b1 || n > 20 * TICK_DIV + 1) begin
            bad++; $display("FAIL irq7_rise got=%b after %0d cycles want=1 within %0d", irq7, n, 20 * TICK_DIV + 1);
        end
        wr(CLINT_MTIMECMP_HI_OFF, 32'hFFFF_FFFF, 4'hF);
        @(negedge clk);
        total++; if (irq7 !== 1'b1) begin bad++; $display("FAIL irq7_lag got=%b want=1", irq7); end
        @(negedge clk);
        total++; if (irq7 !== 1'b0) begin bad++; $display("FAIL irq7_fall got=%b want=0", irq7); end
    endtask

    task automatic test_msip;
        wr(CLINT_MSIP_OFF, 32'h1, 4'hF);
        @(negedge clk);
        total++; if (irq3 !== 1'b1) begin bad++; $display("FAIL irq3_set got=%b want=1", irq3); end
        rd_chk(CLINT_MSIP_OFF, 32'h1, "msip_set");
        wr(CLINT_MSIP_OFF, 32'hFFFF_FFFE, 4'hF);
        @(negedge clk);
        total++; if (irq3 !== 1'b0) begin bad++; $display("FAIL irq3_clr got=%b want=0", irq3); end
        rd_chk(CLINT_MSIP_OFF, 32'h0, "msip_clr");
    endtask

    task automatic test_wstrb;
        wr(CLINT_MTIMECMP_LO_OFF, 32'hFFFF_FFFF, 4'hF);
        wr(CLINT_MTIMECMP_LO_OFF, 32'hAABB_CCDD, 4'b0101);
        rd_chk(CLINT_MTIMECMP_LO_OFF, 32'hFFBB_FFDD, "wstrb_merge");
        rd_chk(16'h4003, 32'hFFBB_FFDD, "addr_lsb_ignored");
        wr(16'h1234, 32'hDEAD_BEEF, 4'hF);
        rd_chk(16'h1234, 32'h0, "unmapped");
    endtask

    task automatic test_back_to_back;
        logic [31:0] e;
        @(negedge clk);
        bus.sel = 1'b1; bus.valid = 1'b1; bus.addr = CLINT_MTIMECMP_HI_OFF; bus.wstrb = 4'b0;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(i % 2 == 0 ? 32'hFFFF_FFFF : 32'h0);
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (bus.ready !== (i % 2 == 0) || bus.rdata !== e) begin
                bad++;
                $display("FAIL b2b_%0d got ready=%b rdata=%h want ready=%b rdata=%h", i, bus.ready, bus.rdata, i % 2 == 0, e);
            end
        end
        bus.sel = 1'b0; bus.valid = 1'b0;
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        bus.sel = 1'b1; bus.valid = 1'b1; bus.addr = CLINT_MSIP_OFF; bus.wdata = 32'h1; bus.wstrb = 4'hF;
        @(negedge clk);
        total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL mid_resp got=%b want=1", bus.ready); end
        resetn = 1'b0;
        @(negedge clk);
        total++; if (bus.ready !== 1'b0 || irq3 !== 1'b0) begin
            bad++; $display("FAIL mid_reset got ready=%b irq3=%b want 0 0", bus.ready, irq3);
        end
        bus.sel = 1'b0; bus.valid = 1'b0; bus.wstrb = 4'b0;
        resetn = 1'b1;
        rd_chk(CLINT_MSIP_OFF, 32'h0, "mid_msip");
        total++; if (irq3 !== 1'b0) begin bad++; $display("FAIL mid_irq3 got=%b want=0", irq3); end
    endtask

    initial begin
        test_reset;
        test_tick;
        test_carry;
        test_timer_irq;
        test_msip;
        test_wstrb;
        test_back_to_back;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
